// File: rtl/sti_unpack_if.sv
// Bus bundle for the STI unpack stage: start/busy/done handshake, stimulus ROM
// read port and result RAM write port.
interface sti_unpack_if;
   logic        start;
   logic        busy;
   logic        done;
   logic        sti_rd;
   logic [9:0]  sti_addr;
   logic [15:0] sti_di;
   logic        res_wr;
   logic [13:0] res_addr;
   logic [7:0]  res_do;
   logic [14:0] obj_cnt;

   // Unpack block side.
   modport master (
      input  start, sti_di,
      output busy, done, sti_rd, sti_addr, res_wr, res_addr, res_do, obj_cnt
   );

   // Controller / memory side.
   modport slave (
      output start, sti_di,
      input  busy, done, sti_rd, sti_addr, res_wr, res_addr, res_do, obj_cnt
   );
endinterface

// File: rtl/sti_unpack.sv
// Expands the 1024x16 packed binary image into 16384 byte pixels, optionally
// clearing the one-pixel image border, and counts object pixels written.
// The next ROM word is fetched during the last bit of the current word, so
// RAM writes run back to back for the whole image.
module sti_unpack #(
   parameter int         FORCE_BORDER = 1,
   parameter logic [7:0] OBJ_VAL      = 8'd1
) (
   input  logic         clk,
   input  logic         reset,
   sti_unpack_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [9:0]  word_reg, word_next;
   logic [3:0]  bit_cnt_reg, bit_cnt_next;
   logic [15:0] shift_reg, shift_next;
   logic [14:0] obj_cnt_reg, obj_cnt_next;
   logic        busy_reg, busy_next;
   logic        done_reg, done_next;

   logic        sti_rd_c;
   logic [9:0]  sti_addr_c;
   logic        res_wr_c;
   logic [13:0] res_addr_c;
   logic [7:0]  res_do_c;

   logic [6:0]  pix_row;
   logic [6:0]  pix_col;
   logic        on_border;
   logic        is_obj;

   // Position of the pixel currently being written: row from the word index,
   // column from the word's slot in the row plus the bit counter.
   assign pix_row   = word_reg[9:3];
   assign pix_col   = {word_reg[2:0], bit_cnt_reg};
   assign on_border = (FORCE_BORDER != 0) &&
                      ((pix_row == 7'd0) || (pix_row == 7'd127) ||
                       (pix_col == 7'd0) || (pix_col == 7'd127));
   assign is_obj    = shift_reg[15] && !on_border;

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         word_reg    <= '0;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         obj_cnt_reg <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         word_reg    <= word_next;
         bit_cnt_reg <= bit_cnt_next;
         shift_reg   <= shift_next;
         obj_cnt_reg <= obj_cnt_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
      end
   end

   // Next-state logic and the ROM/RAM strobes.
   always_comb begin
      state_next   = state_reg;
      word_next    = word_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      obj_cnt_next = obj_cnt_reg;
      busy_next    = busy_reg;
      done_next    = 1'b0;
      sti_rd_c     = 1'b0;
      sti_addr_c   = word_reg;
      res_wr_c     = 1'b0;
      res_addr_c   = '0;
      res_do_c     = '0;

      case (state_reg)
         IDLE: begin
            // The cycle carrying done still counts as the end of the previous
            // run, so a start coinciding with it is dropped.
            if (bus.start && !done_reg) begin
               state_next   = READ;
               word_next    = '0;
               obj_cnt_next = '0;
               busy_next    = 1'b1;
            end
         end

         READ: begin
            sti_rd_c     = 1'b1;
            shift_next   = bus.sti_di;
            bit_cnt_next = '0;
            state_next   = WRITE;
         end

         WRITE: begin
            res_wr_c     = 1'b1;
            res_addr_c   = {word_reg, bit_cnt_reg};
            res_do_c     = is_obj ? OBJ_VAL : 8'd0;
            shift_next   = {shift_reg[14:0], 1'b0};
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (is_obj) begin
               obj_cnt_next = obj_cnt_reg + 15'd1;
            end
            if (bit_cnt_reg == 4'd15) begin
               if (word_reg != 10'd1023) begin
                  // Prefetch the next word so its first pixel follows
                  // immediately after this word's last pixel.
                  sti_rd_c     = 1'b1;
                  sti_addr_c   = word_reg + 10'd1;
                  shift_next   = bus.sti_di;
                  word_next    = word_reg + 10'd1;
                  bit_cnt_next = '0;
               end else begin
                  state_next = IDLE;
                  done_next  = 1'b1;
                  busy_next  = 1'b0;
               end
            end
         end

         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

   assign bus.busy     = busy_reg;
   assign bus.done     = done_reg;
   assign bus.obj_cnt  = obj_cnt_reg;
   assign bus.sti_rd   = sti_rd_c;
   assign bus.sti_addr = sti_addr_c;
   assign bus.res_wr   = res_wr_c;
   assign bus.res_addr = res_addr_c;
   assign bus.res_do   = res_do_c;

endmodule
